// File: rtl/dmem_arbiter.sv
// Shares one data memory between the core MEM stage and an external (debug/DMA) port.
// The core has priority; a starvation counter forces one external access after STARVE_LIMIT lost cycles.
module dmem_arbiter #(
    parameter int DMEM_ADDR_WIDTH = 12,
    parameter int DMEM_WORD_WIDTH = 16,
    parameter int STARVE_LIMIT    = 4,
    parameter int CNT_WIDTH       = 3
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_core_rd_en,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_core_rd_addr,
    input  logic                       in_core_wr_en,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_core_wr_addr,
    input  logic [DMEM_WORD_WIDTH-1:0] in_core_wr_word,
    output logic [DMEM_WORD_WIDTH-1:0] out_core_rd_word,
    output logic                       out_core_stall,
    input  logic                       in_ext_req,
    input  logic                       in_ext_we,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_ext_addr,
    input  logic [DMEM_WORD_WIDTH-1:0] in_ext_wr_word,
    output logic                       out_ext_gnt,
    output logic                       out_ext_rvalid,
    output logic [DMEM_WORD_WIDTH-1:0] out_ext_rd_word,
    output logic [DMEM_ADDR_WIDTH-1:0] out_dmem_rd_addr,
    output logic [DMEM_ADDR_WIDTH-1:0] out_dmem_wr_addr,
    output logic [DMEM_WORD_WIDTH-1:0] out_dmem_wr_word,
    output logic                       out_dmem_write_en,
    input  logic [DMEM_WORD_WIDTH-1:0] in_dmem_rd_word
);

    localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STARVE_LIMIT);

    logic [CNT_WIDTH-1:0] wait_cnt;
    logic                 rd_owner_q;
    logic                 rvalid_q;
    logic                 core_act;
    logic                 force_ext;
    logic                 ext_win;

    assign core_act  = in_core_rd_en | in_core_wr_en;
    assign force_ext = in_ext_req & (wait_cnt == LIMIT);
    assign ext_win   = in_ext_req & (~core_act | force_ext);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt   <= '0;
            rd_owner_q <= 1'b0;
            rvalid_q   <= 1'b0;
        end else begin
            if (ext_win | ~in_ext_req) begin
                wait_cnt <= '0;
            end else if (wait_cnt != LIMIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            rvalid_q   <= ext_win & ~in_ext_we;
            rd_owner_q <= ext_win;
        end
    end

    // Outputs are gated by reset so nothing reaches the memory while reset is high.
    always_comb begin
        out_ext_gnt       = 1'b0;
        out_core_stall    = 1'b0;
        out_dmem_rd_addr  = '0;
        out_dmem_wr_addr  = '0;
        out_dmem_wr_word  = '0;
        out_dmem_write_en = 1'b0;
        out_ext_rvalid    = 1'b0;
        out_ext_rd_word   = '0;
        out_core_rd_word  = '0;
        if (!reset) begin
            out_ext_gnt    = ext_win;
            out_core_stall = force_ext & core_act;
            if (ext_win) begin
                out_dmem_rd_addr  = in_ext_addr;
                out_dmem_wr_addr  = in_ext_addr;
                out_dmem_wr_word  = in_ext_wr_word;
                out_dmem_write_en = in_ext_we;
            end else begin
                out_dmem_rd_addr  = in_core_rd_addr;
                out_dmem_wr_addr  = in_core_wr_addr;
                out_dmem_wr_word  = in_core_wr_word;
                out_dmem_write_en = in_core_wr_en;
            end
            out_ext_rvalid   = rvalid_q;
            out_ext_rd_word  = rvalid_q ? in_dmem_rd_word : '0;
            // The core never sees data returned for an external read.
            out_core_rd_word = rd_owner_q ? '0 : in_dmem_rd_word;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: bench-owned DMEM, directed test-plan steps, then constrained-random traffic.
module tb_dmem_arbiter;

    localparam int AW    = 12;
    localparam int DW    = 16;
    localparam int LIMIT = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_core_rd_en;
    logic [AW-1:0] in_core_rd_addr;
    logic          in_core_wr_en;
    logic [AW-1:0] in_core_wr_addr;
    logic [DW-1:0] in_core_wr_word;
    logic [DW-1:0] out_core_rd_word;
    logic          out_core_stall;
    logic          in_ext_req;
    logic          in_ext_we;
    logic [AW-1:0] in_ext_addr;
    logic [DW-1:0] in_ext_wr_word;
    logic          out_ext_gnt;
    logic          out_ext_rvalid;
    logic [DW-1:0] out_ext_rd_word;
    logic [AW-1:0] out_dmem_rd_addr;
    logic [AW-1:0] out_dmem_wr_addr;
    logic [DW-1:0] out_dmem_wr_word;
    logic          out_dmem_write_en;
    logic [DW-1:0] in_dmem_rd_word;

    dmem_arbiter #(
        .DMEM_ADDR_WIDTH(AW), .DMEM_WORD_WIDTH(DW), .STARVE_LIMIT(LIMIT), .CNT_WIDTH(3)
    ) dut (
        .clock(clock), .reset(reset),
        .in_core_rd_en(in_core_rd_en), .in_core_rd_addr(in_core_rd_addr),
        .in_core_wr_en(in_core_wr_en), .in_core_wr_addr(in_core_wr_addr),
        .in_core_wr_word(in_core_wr_word),
        .out_core_rd_word(out_core_rd_word), .out_core_stall(out_core_stall),
        .in_ext_req(in_ext_req), .in_ext_we(in_ext_we), .in_ext_addr(in_ext_addr),
        .in_ext_wr_word(in_ext_wr_word),
        .out_ext_gnt(out_ext_gnt), .out_ext_rvalid(out_ext_rvalid), .out_ext_rd_word(out_ext_rd_word),
        .out_dmem_rd_addr(out_dmem_rd_addr), .out_dmem_wr_addr(out_dmem_wr_addr),
        .out_dmem_wr_word(out_dmem_wr_word), .out_dmem_write_en(out_dmem_write_en),
        .in_dmem_rd_word(in_dmem_rd_word)
    );

    always #5 clock = ~clock;

    // dmem: memory driven by the DUT's outputs; gmem: reference memory updated by the model.
    logic [DW-1:0] dmem [0:(1<<AW)-1];
    logic [DW-1:0] gmem [0:(1<<AW)-1];

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: lost cycles of the pending external request, pending returns.
    int            lost;
    bit            exp_rv;
    logic [DW-1:0] exp_ext_word;
    bit            owner_ext;
    logic [DW-1:0] exp_core_word;
    bit            core_known;

    logic          obs_gnt, obs_stall, obs_rv;
    logic [DW-1:0] obs_ext_word, obs_core_word;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs already driven after a falling edge; check, then model the rising edge.
    task automatic cyc();
        bit            core_act, win, exp_we;
        logic [AW-1:0] ra_s, wa_s;
        logic [DW-1:0] wd_s, old_ext, old_core;
        logic          we_s;
        #1;
        obs_gnt       = out_ext_gnt;
        obs_stall     = out_core_stall;
        obs_rv        = out_ext_rvalid;
        obs_ext_word  = out_ext_rd_word;
        obs_core_word = out_core_rd_word;
        ra_s = out_dmem_rd_addr;
        wa_s = out_dmem_wr_addr;
        wd_s = out_dmem_wr_word;
        we_s = out_dmem_write_en;
        if (reset) begin
            chk("rst_gnt", out_ext_gnt, 0);
            chk("rst_stall", out_core_stall, 0);
            chk("rst_write_en", out_dmem_write_en, 0);
            chk("rst_rvalid", out_ext_rvalid, 0);
            chk("rst_ext_word", out_ext_rd_word, 0);
            chk("rst_core_word", out_core_rd_word, 0);
            @(posedge clock);
            in_dmem_rd_word = dmem[ra_s];
            if (we_s === 1'b1) dmem[wa_s] = wd_s;
            lost = 0; exp_rv = 0; owner_ext = 0; core_known = 0;
            @(negedge clock);
            return;
        end
        core_act = in_core_rd_en || in_core_wr_en;
        win      = in_ext_req && (!core_act || lost >= LIMIT);
        exp_we   = win ? in_ext_we : in_core_wr_en;
        chk("gnt", out_ext_gnt, win);
        chk("stall", out_core_stall, win && core_act);
        chk("write_en", out_dmem_write_en, exp_we);
        if (win) begin
            chk("ext_rd_addr", out_dmem_rd_addr, in_ext_addr);
            if (in_ext_we) begin
                chk("ext_wr_addr", out_dmem_wr_addr, in_ext_addr);
                chk("ext_wr_word", out_dmem_wr_word, in_ext_wr_word);
            end
        end else begin
            if (in_core_rd_en) chk("core_rd_addr", out_dmem_rd_addr, in_core_rd_addr);
            if (in_core_wr_en) begin
                chk("core_wr_addr", out_dmem_wr_addr, in_core_wr_addr);
                chk("core_wr_word", out_dmem_wr_word, in_core_wr_word);
            end
        end
        chk("rvalid", out_ext_rvalid, exp_rv);
        chk("ext_rd_word", out_ext_rd_word, exp_rv ? exp_ext_word : '0);
        if (core_known) chk("core_rd_word", out_core_rd_word, owner_ext ? '0 : exp_core_word);
        @(posedge clock);
        in_dmem_rd_word = dmem[ra_s];
        if (we_s === 1'b1) dmem[wa_s] = wd_s;
        old_ext  = gmem[in_ext_addr];
        old_core = gmem[in_core_rd_addr];
        if (win) begin
            exp_rv       = !in_ext_we;
            exp_ext_word = old_ext;
            owner_ext    = 1;
            if (in_ext_we) gmem[in_ext_addr] = in_ext_wr_word;
        end else begin
            exp_rv        = 0;
            owner_ext     = 0;
            exp_core_word = old_core;
            if (in_core_wr_en) gmem[in_core_wr_addr] = in_core_wr_word;
        end
        core_known = 1;
        if (!in_ext_req || win) lost = 0;
        else if (lost < LIMIT) lost++;
        @(negedge clock);
    endtask

    task automatic core_set(input bit rd, input logic [AW-1:0] ra, input bit wr,
                            input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        in_core_rd_en = rd; in_core_rd_addr = ra;
        in_core_wr_en = wr; in_core_wr_addr = wa; in_core_wr_word = wd;
    endtask

    task automatic ext_set(input bit req, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        in_ext_req = req; in_ext_we = we; in_ext_addr = a; in_ext_wr_word = wd;
    endtask

    initial begin
        int found;
        logic st;
        logic [DW-1:0] v;
        for (int i = 0; i < (1 << AW); i++) begin
            v = DW'($urandom);
            dmem[i] = v;
            gmem[i] = v;
        end
        dmem[12'h010] = 16'hBEEF; gmem[12'h010] = 16'hBEEF;
        dmem[12'h030] = 16'h5555; gmem[12'h030] = 16'h5555;
        dmem[12'h001] = 16'h1111; gmem[12'h001] = 16'h1111;
        dmem[12'h002] = 16'h2222; gmem[12'h002] = 16'h2222;
        lost = 0; exp_rv = 0; owner_ext = 0; core_known = 0;
        exp_ext_word = '0; exp_core_word = '0;
        in_dmem_rd_word = '0;
        reset = 1'b1;
        core_set(0, 0, 0, 0, 0);
        ext_set(1, 1, 12'h00F, 16'hFFFF);
        @(negedge clock);
        cyc(); cyc();
        reset = 1'b0;

        // Ext read, core idle
        ext_set(1, 0, 12'h010, 0);
        cyc();
        chk("t1_gnt", obs_gnt, 1); chk("t1_stall", obs_stall, 0);
        ext_set(0, 0, 0, 0);
        cyc();
        chk("t1_rvalid", obs_rv, 1); chk("t1_word", obs_ext_word, 16'hBEEF);

        // Ext write, then core read back
        ext_set(1, 1, 12'h020, 16'h1234);
        cyc();
        ext_set(0, 0, 0, 0);
        core_set(1, 12'h020, 0, 0, 0);
        cyc();
        core_set(0, 12'h020, 0, 0, 0);
        cyc();
        chk("t2_core_word", obs_core_word, 16'h1234);

        // Starvation: forced grant on the 5th cycle
        core_set(1, 12'h040, 0, 0, 0);
        ext_set(1, 0, 12'h050, 0);
        found = 0; st = 1'b0;
        for (int i = 1; i <= 8 && found == 0; i++) begin
            cyc();
            if (obs_gnt === 1'b1) begin found = i; st = obs_stall; end
        end
        chk("t3_gnt_cycle", found, 5);
        chk("t3_stall", st, 1);
        ext_set(1, 0, 12'h051, 0);
        cyc();
        chk("t3_core_served_gnt", obs_gnt, 0); chk("t3_core_served_stall", obs_stall, 0);
        core_set(0, 0, 0, 0, 0);
        cyc();
        chk("t3_idle_gnt", obs_gnt, 1);
        ext_set(0, 0, 0, 0);
        cyc();

        // Forced conflict: core write and ext read at the same address
        core_set(1, 12'h031, 0, 0, 0);
        ext_set(1, 0, 12'h030, 0);
        for (int i = 0; i < LIMIT; i++) begin
            cyc();
            chk("t4_lost_gnt", obs_gnt, 0);
        end
        core_set(0, 0, 1, 12'h030, 16'hAAAA);
        cyc();
        chk("t4_forced_gnt", obs_gnt, 1); chk("t4_forced_stall", obs_stall, 1);
        ext_set(0, 0, 0, 0);
        cyc();
        chk("t4_rvalid", obs_rv, 1); chk("t4_old_word", obs_ext_word, 16'h5555);
        chk("t4_retry_stall", obs_stall, 0);
        core_set(1, 12'h030, 0, 0, 0);
        cyc();
        core_set(0, 12'h030, 0, 0, 0);
        cyc();
        chk("t4_new_word", obs_core_word, 16'hAAAA);

        // Back-to-back ext reads
        ext_set(1, 0, 12'h001, 0);
        cyc();
        chk("t5_gnt0", obs_gnt, 1);
        ext_set(1, 0, 12'h002, 0);
        cyc();
        chk("t5_gnt1", obs_gnt, 1);
        chk("t5_rv0", obs_rv, 1); chk("t5_word0", obs_ext_word, 16'h1111); chk("t5_core0", obs_core_word, 0);
        ext_set(0, 0, 0, 0);
        cyc();
        chk("t5_rv1", obs_rv, 1); chk("t5_word1", obs_ext_word, 16'h2222); chk("t5_core1", obs_core_word, 0);

        // Reset in the cycle after a read grant
        ext_set(1, 0, 12'h010, 0);
        cyc();
        chk("t6_gnt", obs_gnt, 1);
        ext_set(1, 1, 12'h060, 16'h7777);
        core_set(0, 0, 1, 12'h061, 16'h6666);
        reset = 1'b1;
        #1;
        chk("t6_rvalid_now", out_ext_rvalid, 0);
        chk("t6_word_now", out_ext_rd_word, 0);
        cyc(); cyc();
        reset = 1'b0;
        core_set(1, 12'h063, 0, 0, 0);
        ext_set(1, 0, 12'h062, 0);
        found = 0;
        for (int i = 1; i <= 8 && found == 0; i++) begin
            cyc();
            if (obs_gnt === 1'b1) found = i;
        end
        chk("t6_cnt_cleared", found, 5);
        chk("t6_no_write_ext", dmem[12'h060], gmem[12'h060]);
        chk("t6_no_write_core", dmem[12'h061], gmem[12'h061]);
        ext_set(0, 0, 0, 0);
        core_set(0, 0, 0, 0, 0);
        cyc();

        // Random traffic on a small address window; requester holds until granted, core holds while stalled
        for (int k = 0; k < 400; k++) begin
            if (k == 200) reset = 1'b1;
            if (k == 202) reset = 1'b0;
            if (!in_ext_req || obs_gnt === 1'b1 || k == 202) begin
                ext_set(($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                        AW'($urandom_range(0, 15)), DW'($urandom));
            end
            if (obs_stall !== 1'b1 || k == 202) begin
                core_set(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
                         ($urandom_range(0, 3) == 0), AW'($urandom_range(0, 15)), DW'($urandom));
            end
            cyc();
        end
        for (int i = 0; i < 16; i++) chk("final_mem", dmem[i], gmem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data memory between two requesters: the core MEM stage and an external requester (debug/DMA loader port).
- Sits between mem/dmem_sim in swt16_top. The core normally has priority.
- A starvation counter forces one external access after STARVE_LIMIT consecutive lost cycles. During that access the core is stalled.
- Tracks read-data ownership across the one-cycle DMEM read latency.

Parameters:
DMEM_ADDR_WIDTH, 12, DMEM address width
DMEM_WORD_WIDTH, 16, DMEM data width
STARVE_LIMIT, 4, consecutive lost cycles before external access is forced (>=1)
CNT_WIDTH, 3, width of the starvation counter (must hold STARVE_LIMIT)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
in_core_rd_en  in  1  core read request this cycle
in_core_rd_addr  in  DMEM_ADDR_WIDTH  core read address
in_core_wr_en  in  1  core write request this cycle
in_core_wr_addr  in  DMEM_ADDR_WIDTH  core write address
in_core_wr_word  in  DMEM_WORD_WIDTH  core write data
out_core_rd_word  out  DMEM_WORD_WIDTH  read data to core
out_core_stall  out  1  core must hold its MEM-stage request this cycle
in_ext_req  in  1  external request valid
in_ext_we  in  1  1 = write, 0 = read
in_ext_addr  in  DMEM_ADDR_WIDTH  external address
in_ext_wr_word  in  DMEM_WORD_WIDTH  external write data
out_ext_gnt  out  1  external request accepted this cycle
out_ext_rvalid  out  1  external read data valid
out_ext_rd_word  out  DMEM_WORD_WIDTH  external read data
out_dmem_rd_addr  out  DMEM_ADDR_WIDTH  to dmem in_addr_rd
out_dmem_wr_addr  out  DMEM_ADDR_WIDTH  to dmem in_addr_wr
out_dmem_wr_word  out  DMEM_WORD_WIDTH  to dmem in_word
out_dmem_write_en  out  1  to dmem in_write_en
in_dmem_rd_word  in  DMEM_WORD_WIDTH  from dmem out_word

Behaviour:
- Core active (core_act) = in_core_rd_en | in_core_wr_en.
- DMEM read data appears on in_dmem_rd_word one cycle after the read address.
- Registered state:
  - wait_cnt (CNT_WIDTH)
  - rd_owner_q (0 = core, 1 = ext)
  - rvalid_q
- Reset values: wait_cnt = 0, rd_owner_q = 0, rvalid_q = 0. All outputs read 0 while reset is asserted; this includes out_dmem_write_en, out_ext_gnt, out_core_stall and out_ext_rvalid.
- Grant decision (combinational, per cycle):
  - force = in_ext_req & (wait_cnt == STARVE_LIMIT).
  - ext_win = in_ext_req & (~core_act | force).
  - out_ext_gnt = ext_win.
  - out_core_stall = force & core_act.
- DMEM mux:
  - When ext_win: rd_addr and wr_addr = in_ext_addr, wr_word = in_ext_wr_word, write_en = in_ext_we.
  - Otherwise: core signals pass through, and write_en = in_core_wr_en.
  - When neither side is active: write_en = 0 and addresses hold the core inputs.
- Starvation counter (next cycle):
  - ext_win, or in_ext_req = 0: wait_cnt <= 0.
  - in_ext_req & ~ext_win: wait_cnt <= wait_cnt + 1. It saturates at STARVE_LIMIT and never wraps.
- Read return:
  - rvalid_q <= ext_win & ~in_ext_we.
  - rd_owner_q <= ext_win.
  - out_ext_rvalid = rvalid_q.
  - out_ext_rd_word = rvalid_q ? in_dmem_rd_word : 0.
  - out_core_rd_word = rd_owner_q ? 0 : in_dmem_rd_word. The core never sees external data.
- External handshake:
  - The requester holds req/we/addr/wr_word stable until it sees gnt.
  - gnt is a one-cycle pulse, asserted in the cycle the access reaches DMEM.
  - A write completes at the clock edge ending the gnt cycle.
  - Read data arrives exactly one cycle after gnt.
  - A new request may be presented in the cycle after gnt. Back-to-back external reads give rvalid on consecutive cycles.
- Core handshake:
  - While out_core_stall = 1, the pipeline holds its MEM-stage inputs. The core access is retried the following cycle and always wins it, because wait_cnt is 0.
  - A forced ext access therefore costs the core exactly one cycle.
- Simultaneous events:
  - Core write and ext read to the same address in a forced cycle: only the ext read is performed. It returns the old data; the core write lands in the next cycle.
  - in_ext_req dropped before gnt: illegal. The counter clears and no access is made.
- Reset mid-operation: a pending rvalid is discarded, wait_cnt clears, and no DMEM write is issued while reset is high.

Test Plan:
1. Ext read with core idle: DMEM[0x010] = 0xBEEF, ext_req read @0x010 → gnt in the same cycle; rvalid = 1 and rd_word = 0xBEEF next cycle; core_stall stays 0.
2. Ext write with core idle: ext write 0x1234 @0x020, then core read @0x020 → core_rd_word = 0x1234 one cycle after the core read.
3. Starvation, STARVE_LIMIT = 4: core_rd_en held high, ext_req high → gnt asserted on the 5th cycle with core_stall = 1 in that cycle; the core is served in the 6th cycle and wait_cnt returns to 0.
4. Forced conflict: core write 0xAAAA and ext read both @0x030 (old value 0x5555) in the forced cycle → ext_rd_word = 0x5555; DMEM[0x030] = 0xAAAA after the next cycle.
5. Back-to-back ext reads @0x001 and @0x002 with core idle → gnt on 2 consecutive cycles; rvalid on 2 consecutive cycles carrying the matching data; out_core_rd_word = 0 in both return cycles.
6. Reset mid-read: assert reset in the cycle after gnt → rvalid = 0 immediately; wait_cnt = 0; write_en = 0 throughout reset.
